// File: rtl/pc_sequencer.sv
// Program counter sequencer: increment/wrap, absolute jump, relative branch and
// call/return through a small LIFO return stack, with range and stack fault flags.
module pc_sequencer #(
    parameter int N           = 8,
    parameter int DEPTH       = 9,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             jump,
    input  logic [N-1:0]                     jump_addr,
    input  logic                             branch_en,
    input  logic                             branch_cond,
    input  logic [N-1:0]                     branch_off,
    input  logic                             call,
    input  logic                             ret,
    output logic [N-1:0]                     counter,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             addr_err,
    output logic                             stack_ovf,
    output logic                             stack_unf
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [N-1:0]   LAST    = N'(DEPTH - 1);
    localparam logic [N:0]     DEPTH_U = (N + 1)'(DEPTH);
    localparam logic [N+1:0]   DEPTH_B = (N + 2)'(DEPTH);
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    logic [N-1:0]   stack_mem [0:(2**AW)-1];

    logic [N-1:0]   counter_next;
    logic [SPW-1:0] sp_next;
    logic           addr_err_next;
    logic           stack_ovf_next;
    logic           stack_unf_next;
    logic           push_en;

    logic [N-1:0]   incr;
    logic [N-1:0]   top;
    logic [SPW-1:0] sp_dec;
    logic           jump_bad;
    logic [N-1:0]   jump_tgt;
    logic [N+1:0]   branch_tgt;
    logic           branch_bad;

    assign incr     = (counter == LAST) ? '0 : counter + N'(1);
    assign sp_dec   = sp - SPW'(1);
    assign top      = stack_mem[sp_dec[AW-1:0]];
    assign jump_bad = ({1'b0, jump_addr} >= DEPTH_U);
    assign jump_tgt = jump_bad ? '0 : jump_addr;

    // Two extra bits hold the sign and the carry, so a negative or overflowing
    // target is caught instead of wrapping modulo 2**N.
    assign branch_tgt = {2'b00, counter} + {{2{branch_off[N-1]}}, branch_off};
    assign branch_bad = branch_tgt[N+1] || (branch_tgt >= DEPTH_B);

    always_comb begin
        counter_next   = counter;
        sp_next        = sp;
        addr_err_next  = 1'b0;
        stack_ovf_next = stack_ovf;
        stack_unf_next = stack_unf;
        push_en        = 1'b0;
        if (stall) begin
            counter_next = counter;
        end else if (ret) begin
            if (sp != '0) begin
                counter_next = top;
                sp_next      = sp_dec;
            end else begin
                stack_unf_next = 1'b1;
                counter_next   = incr;
            end
        end else if (call) begin
            if (sp < SP_FULL) begin
                push_en       = 1'b1;
                sp_next       = sp + SPW'(1);
                counter_next  = jump_tgt;
                addr_err_next = jump_bad;
            end else begin
                stack_ovf_next = 1'b1;
                counter_next   = incr;
            end
        end else if (jump) begin
            counter_next  = jump_tgt;
            addr_err_next = jump_bad;
        end else if (branch_en && branch_cond) begin
            counter_next  = branch_bad ? '0 : branch_tgt[N-1:0];
            addr_err_next = branch_bad;
        end else begin
            counter_next = incr;
        end
    end

    // Return stack storage is never reset; sp alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[sp[AW-1:0]] <= incr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter   <= '0;
            sp        <= '0;
            addr_err  <= 1'b0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            counter   <= counter_next;
            sp        <= sp_next;
            addr_err  <= addr_err_next;
            stack_ovf <= stack_ovf_next;
            stack_unf <= stack_unf_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random stimulus for pc_sequencer, checked against a queue-based
// model of the program counter and return stack.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall, jump, branch_en, branch_cond, call, ret;
    logic [7:0] jump_addr, branch_off;
    logic [7:0] counter;
    logic [2:0] sp;
    logic       addr_err, stack_ovf, stack_unf;

    int passed = 0;
    int total  = 0;

    int m_pc;
    int m_q[$];
    bit m_err, m_ovf, m_unf;

    pc_sequencer #(.N(8), .DEPTH(9), .STACK_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .jump       (jump),
        .jump_addr  (jump_addr),
        .branch_en  (branch_en),
        .branch_cond(branch_cond),
        .branch_off (branch_off),
        .call       (call),
        .ret        (ret),
        .counter    (counter),
        .sp         (sp),
        .addr_err   (addr_err),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".counter"}, 32'(counter), 32'(m_pc));
        check({tag, ".sp"}, 32'(sp), 32'(m_q.size()));
        check({tag, ".addr_err"}, 32'(addr_err), 32'(m_err));
        check({tag, ".ovf"}, 32'(stack_ovf), 32'(m_ovf));
        check({tag, ".unf"}, 32'(stack_unf), 32'(m_unf));
        $display("%-10s stall=%0d ret=%0d call=%0d jump=%0d ja=%0d br=%0d/%0d off=%0d -> pc=%0d sp=%0d err=%0d ovf=%0d unf=%0d",
                 tag, stall, ret, call, jump, jump_addr, branch_en, branch_cond,
                 $signed(branch_off), counter, sp, addr_err, stack_ovf, stack_unf);
    endtask

    function automatic void model_reset();
        m_pc = 0;
        m_q.delete();
        m_err = 0;
        m_ovf = 0;
        m_unf = 0;
    endfunction

    // Set a target; anything outside 0..8 lands on 0 and raises the error pulse.
    function automatic void model_goto(input int t);
        if (t >= 0 && t < 9) m_pc = t;
        else begin
            m_pc  = 0;
            m_err = 1;
        end
    endfunction

    function automatic void model_step();
        int nxt;
        nxt   = (m_pc + 1) % 9;
        m_err = 0;
        if (stall) return;
        if (ret) begin
            if (m_q.size() > 0) m_pc = m_q.pop_back();
            else begin
                m_unf = 1;
                m_pc  = nxt;
            end
        end else if (call) begin
            if (m_q.size() < 4) begin
                m_q.push_back(nxt);
                model_goto(int'(jump_addr));
            end else begin
                m_ovf = 1;
                m_pc  = nxt;
            end
        end else if (jump) model_goto(int'(jump_addr));
        else if (branch_en && branch_cond) model_goto(m_pc + int'($signed(branch_off)));
        else m_pc = nxt;
    endfunction

    task automatic idle_inputs();
        stall = 0; jump = 0; jump_addr = 0; branch_en = 0; branch_cond = 0;
        branch_off = 0; call = 0; ret = 0;
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) step("idle");
        check("wrap_end", 32'(counter), 32'd3);

        branch_en = 1; branch_cond = 1; branch_off = 8'hFE;
        step("br_back");
        check("br_back_pc", 32'(counter), 32'd1);
        branch_off = 8'h0A;
        step("br_oob");
        check("br_oob_err", 32'(addr_err), 32'd1);
        branch_cond = 0;
        step("br_nt");
        idle_inputs();
        step("idle");
        check("err_pulse_end", 32'(addr_err), 32'd0);

        call = 1; jump_addr = 8'd6;
        step("call");
        check("call_pc", 32'(counter), 32'd6);
        call = 0; ret = 1;
        step("ret");
        check("ret_pc", 32'(counter), 32'd3);

        ret = 0; call = 1; jump_addr = 8'd5;
        for (int i = 0; i < 5; i++) step("call5");
        check("ovf_pc", 32'(counter), 32'd6);
        check("ovf_flag", 32'(stack_ovf), 32'd1);

        call = 1; ret = 1;
        step("call_ret");
        call = 0;
        for (int i = 0; i < 3; i++) step("ret");
        ret = 0;
        while (m_pc != 7) step("idle");
        ret = 1;
        step("ret_unf");
        check("unf_pc", 32'(counter), 32'd8);
        ret = 0; stall = 1; jump = 1; jump_addr = 8'd2;
        step("stall");
        check("stall_pc", 32'(counter), 32'd8);
        stall = 0; jump_addr = 8'd9;
        step("jump_oob");

        idle_inputs();
        stall = 1; call = 1; jump_addr = 8'd4;
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        step("post_rst");

        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 7) == 0);
            ret         = ($urandom_range(0, 5) == 0);
            call        = ($urandom_range(0, 4) == 0);
            jump        = ($urandom_range(0, 5) == 0);
            jump_addr   = 8'($urandom_range(0, 11));
            branch_en   = $urandom_range(0, 1) == 1;
            branch_cond = $urandom_range(0, 1) == 1;
            branch_off  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 8) - 4);
            if (i == 200) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                check_all("rnd_rst");
                @(negedge clk);
                reset = 1'b1;
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
